// File: rtl/gpr_pkg.sv
// Shared constants and helpers for the multi-port GPR file.
// Used by gpr_file_mp and gpr_wr_arbiter.
package gpr_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/gpr_wr_arbiter.sv
// Per-register write commit and data select over all write ports.
// The highest-numbered committing port wins each address.
module gpr_wr_arbiter
  import gpr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_WR = 2
) (
  input  logic                       stall_W,
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR*ADDR_W-1:0]   wa,
  input  logic [NUM_WR*DATA_W-1:0]   wd,
  output logic [2**ADDR_W-1:0]       commit,
  output logic [(2**ADDR_W)*DATA_W-1:0] wsel
);

  localparam int DEPTH = 2**ADDR_W;

  always_comb begin
    commit = '0;
    wsel   = '0;
    for (int a = REG_ZERO + 1; a < DEPTH; a++) begin
      // Ascending scan: a later hit overrides an earlier one.
      for (int k = 0; k < NUM_WR; k++) begin
        if (we[k] && !stall_W &&
            wa[slice_lo(k, ADDR_W) +: ADDR_W] == ADDR_W'(a)) begin
          commit[a] = 1'b1;
          wsel[slice_lo(a, DATA_W) +: DATA_W] =
            wd[slice_lo(k, DATA_W) +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file with busy scoreboard and async active-low clear.
// Define GPR_BYPASS_EN for same-cycle write-to-read forwarding.
module gpr_file_mp
  import gpr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_W,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]       regs [DEPTH];
  logic [DEPTH-1:0]        busy;
  logic [DEPTH-1:0]        commit;
  logic [DEPTH*DATA_W-1:0] wsel;

  gpr_wr_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_arb (
    .stall_W (stall_W),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .commit  (commit),
    .wsel    (wsel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) regs[a] <= '0;
      busy <= '0;
    end else begin
      for (int a = REG_ZERO + 1; a < DEPTH; a++) begin
        if (commit[a])
          regs[a] <= wsel[slice_lo(a, DATA_W) +: DATA_W];
        // A claim marks a newer producer, so it beats the clear.
        if (claim_en && claim_addr == ADDR_W'(a))
          busy[a] <= 1'b1;
        else if (commit[a])
          busy[a] <= 1'b0;
      end
    end
  end

  assign busy_vec = busy;

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      automatic int a = int'(ra[slice_lo(j, ADDR_W) +: ADDR_W]);
      rd[slice_lo(j, DATA_W) +: DATA_W] = regs[a];
      rd_busy[j] = busy[a];
`ifdef GPR_BYPASS_EN
      if (rst_n && commit[a]) begin
        rd[slice_lo(j, DATA_W) +: DATA_W] =
          wsel[slice_lo(a, DATA_W) +: DATA_W];
        if (!(claim_en && int'(claim_addr) == a))
          rd_busy[j] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed self-checking bench for gpr_file_mp (2 read, 2 write ports).
// Expectations follow GPR_BYPASS_EN when that macro is defined.
module tb_gpr_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_W;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rd_busy;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic [31:0] busy_vec;

  int checks = 0;
  int errors = 0;

  gpr_file_mp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_W    (stall_W),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .ra         (ra),
    .rd         (rd),
    .rd_busy    (rd_busy),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .busy_vec   (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 2'b00; wa = '0; wd = '0;
    claim_en = 1'b0; claim_addr = '0;
    stall_W = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] a,
                    input logic [31:0] d);
    we[p] = 1'b1;
    wa[p*5 +: 5] = a;
    wd[p*32 +: 32] = d;
  endtask

  task automatic claim(input logic [4:0] a);
    claim_en = 1'b1;
    claim_addr = a;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    ra = '0;
    #3;
    chk("reset_rd", rd[31:0], 32'h0);
    chk("reset_busy_vec", busy_vec, 32'h0);
    #4 rst_n = 1'b1;
    tick();

    // 1: reset mid-operation
    wr(0, 5'd5, 32'hDEADBEEF);
    claim(5'd7);
    tick();
    idle();
    ra = {5'd7, 5'd5};
    #1;
    chk("t1_r5", rd[31:0], 32'hDEADBEEF);
    chk("t1_busy7", {31'b0, rd_busy[1]}, 32'h1);
    chk("t1_busy_vec", busy_vec, 32'h0000_0080);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_r5", rd[31:0], 32'h0);
    chk("t1_rst_busy_vec", busy_vec, 32'h0);
    chk("t1_rst_rd_busy", {30'b0, rd_busy}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // 2: write collision and distinct-address dual commit
    wr(0, 5'd3, 32'h11);
    wr(1, 5'd3, 32'h22);
    ra = {5'd4, 5'd3};
    #1;
`ifdef GPR_BYPASS_EN
    chk("t2_bypass_r3", rd[31:0], 32'h22);
`else
    chk("t2_pre_r3", rd[31:0], 32'h0);
`endif
    tick();
    idle();
    #1;
    chk("t2_r3", rd[31:0], 32'h22);
    wr(0, 5'd4, 32'h11);
    wr(1, 5'd3, 32'h33);
    tick();
    idle();
    #1;
    chk("t2_r3b", rd[31:0], 32'h33);
    chk("t2_r4", rd[63:32], 32'h11);

    // 3: register zero
    wr(0, 5'd0, 32'hFFFFFFFF);
    claim(5'd0);
    ra = {5'd0, 5'd0};
    #1;
    chk("t3_pre_r0", rd[31:0], 32'h0);
    tick();
    idle();
    #1;
    chk("t3_r0", rd[63:32], 32'h0);
    chk("t3_busy0", {31'b0, busy_vec[0]}, 32'h0);
    chk("t3_rd_busy", {30'b0, rd_busy}, 32'h0);

    // 4: scoreboard claim then write, and same-cycle claim+write
    ra = {5'd9, 5'd9};
    claim(5'd9);
    tick();
    idle();
    #1;
    chk("t4_busy_set", {31'b0, rd_busy[0]}, 32'h1);
    wr(1, 5'd9, 32'h99);
    tick();
    idle();
    #1;
    chk("t4_busy_clr", {31'b0, rd_busy[0]}, 32'h0);
    chk("t4_r9", rd[31:0], 32'h99);
    claim(5'd9);
    wr(0, 5'd9, 32'h9A);
    tick();
    idle();
    #1;
    chk("t4_claim_wins", {31'b0, rd_busy[1]}, 32'h1);
    chk("t4_r9_stored", rd[63:32], 32'h9A);

    // 5: stall holds data and busy, claims still apply
    claim(5'd6);
    tick();
    idle();
    stall_W = 1'b1;
    wr(0, 5'd6, 32'h55);
    claim(5'd10);
    ra = {5'd10, 5'd6};
    tick();
    chk("t5_r6_held", rd[31:0], 32'h0);
    chk("t5_busy6_held", {31'b0, rd_busy[0]}, 32'h1);
    chk("t5_claim_in_stall", {31'b0, rd_busy[1]}, 32'h1);
    stall_W = 1'b0;
    claim_en = 1'b0;
    tick();
    idle();
    #1;
    chk("t5_r6", rd[31:0], 32'h55);
    chk("t5_busy6_clr", {31'b0, rd_busy[0]}, 32'h0);
    chk("t5_busy_vec", busy_vec, 32'h0000_0600);

    // 6: write-to-read bypass
    ra = {5'd12, 5'd12};
    wr(0, 5'd12, 32'h1111);
    claim(5'd12);
    tick();
    idle();
    wr(1, 5'd12, 32'hABCD);
    #1;
`ifdef GPR_BYPASS_EN
    chk("t6_bypass_rd0", rd[31:0], 32'hABCD);
    chk("t6_bypass_rd1", rd[63:32], 32'hABCD);
    chk("t6_bypass_busy", {30'b0, rd_busy}, 32'h0);
`else
    chk("t6_old_rd0", rd[31:0], 32'h1111);
    chk("t6_old_rd1", rd[63:32], 32'h1111);
    chk("t6_old_busy", {30'b0, rd_busy}, 32'h3);
`endif
    tick();
    idle();
    #1;
    chk("t6_post_rd0", rd[31:0], 32'hABCD);
    chk("t6_post_busy", {30'b0, rd_busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
